// File: rtl/video_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : video_frame_writer
//  Description : Terminal sink of the RGB444 stream. Writes each pixel of a
//                sop..eop frame packet to a frame-buffer port at its raster
//                address, checks packet length and reports frame status.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_frame_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [11:0]       data_in,
    input  logic              sop_in,
    input  logic              eop_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    input  logic              mem_ready,
    output logic              frame_done,
    output logic              err_short,
    output logic              err_long,
    output logic [15:0]       frame_count
);

    localparam int              C_N      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(C_N - 1);
    localparam bit              C_N_ONE  = (C_N == 1);

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        ACTIVE   = 2'd1,
        OVERRUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic                r_ovr_first;
    logic                w_ovr_first_nxt;
    logic                w_accept;
    logic                w_load;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_done;
    logic                w_short;
    logic                w_long;

    // The output stage may take a new beat when it is empty or draining now.
    assign ready_out = !reset && (!wr_en || mem_ready);
    assign w_accept  = valid_in && ready_out;

    // Next-state, pixel counter and status decode for an accepted beat.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ovr_first_nxt = r_ovr_first;
        w_load          = 1'b0;
        w_addr          = r_pc;
        w_done          = 1'b0;
        w_short         = 1'b0;
        w_long          = 1'b0;
        if (w_accept) begin
            // The overrun is reported once, on the first beat past the frame.
            if (r_state == OVERRUN && r_ovr_first) begin
                w_long          = 1'b1;
                w_ovr_first_nxt = 1'b0;
            end
            if (sop_in) begin
                // A sop always starts a new frame at address 0; a restart
                // while still inside an unfinished frame is a short frame.
                w_load = 1'b1;
                w_addr = '0;
                if (r_state == ACTIVE) begin
                    w_short = 1'b1;
                end
                if (eop_in) begin
                    w_state_nxt = WAIT_SOP;
                    w_pc_nxt    = '0;
                    if (C_N_ONE) begin
                        w_done = 1'b1;
                    end else begin
                        w_short = 1'b1;
                    end
                end else begin
                    w_state_nxt = ACTIVE;
                    w_pc_nxt    = ADDR_W'(1);
                end
            end else begin
                case (r_state)
                    ACTIVE: begin
                        w_load = 1'b1;
                        w_addr = r_pc;
                        if (eop_in) begin
                            w_state_nxt = WAIT_SOP;
                            w_pc_nxt    = '0;
                            if (r_pc == C_LAST) begin
                                w_done = 1'b1;
                            end else begin
                                w_short = 1'b1;
                            end
                        end else if (r_pc == C_LAST) begin
                            w_state_nxt     = OVERRUN;
                            w_ovr_first_nxt = 1'b1;
                        end else begin
                            w_pc_nxt = r_pc + ADDR_W'(1);
                        end
                    end
                    OVERRUN: begin
                        if (eop_in) begin
                            w_state_nxt = WAIT_SOP;
                            w_pc_nxt    = '0;
                        end
                    end
                    default: begin
                        // Stray beats outside a frame are dropped.
                    end
                endcase
            end
            // Only one status pulse per cycle: long, then short, then done.
            if (w_long) begin
                w_short = 1'b0;
                w_done  = 1'b0;
            end else if (w_short) begin
                w_done = 1'b0;
            end
        end
    end

    // State, counters, output write stage and status pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT_SOP;
            r_pc        <= '0;
            r_ovr_first <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ovr_first <= w_ovr_first_nxt;
            frame_done  <= w_done;
            err_short   <= w_short;
            err_long    <= w_long;
            if (w_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (w_load) begin
                wr_en   <= 1'b1;
                wr_addr <= w_addr;
                wr_data <= data_in;
            end else if (mem_ready) begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_frame_writer
//  Description : Self-checking bench for video_frame_writer (4x2 frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_frame_writer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] data_in;
    logic        sop_in, eop_in, valid_in;
    logic        ready_out;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic        mem_ready;
    logic        frame_done, err_short, err_long;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;

    // Observed DUT activity for the directed, literal checks.
    int wlog[$];
    int dlog[$];
    int n_done, n_short, n_long;

    // Behavioural model: beats since sop, whether inside a frame.
    bit          m_in_frame;
    int          m_beats;
    bit          m_wen;
    int          m_addr;
    logic [11:0] m_data;
    bit          m_done, m_short, m_long;
    logic [15:0] m_cnt;

    video_frame_writer #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in),
        .eop_in(eop_in), .valid_in(valid_in), .ready_out(ready_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_ready(mem_ready), .frame_done(frame_done), .err_short(err_short),
        .err_long(err_long), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit exp_rdy, acc, wr, lg, sh, dn;
        int waddr;
        exp_rdy = !reset && (!m_wen || mem_ready);
        chk("ready_out", int'(ready_out), int'(exp_rdy));
        chk("wr_en", int'(wr_en), int'(m_wen));
        if (m_wen) begin
            chk("wr_addr", int'(wr_addr), m_addr);
            chk("wr_data", int'(wr_data), int'(m_data));
        end
        chk("frame_done", int'(frame_done), int'(m_done));
        chk("err_short", int'(err_short), int'(m_short));
        chk("err_long", int'(err_long), int'(m_long));
        chk("frame_count", int'(frame_count), int'(m_cnt));

        if (wr_en && mem_ready) begin
            wlog.push_back(int'(wr_addr));
            dlog.push_back(int'(wr_data));
        end
        if (frame_done) n_done++;
        if (err_short) n_short++;
        if (err_long) n_long++;

        if (reset) begin
            m_in_frame = 0; m_beats = 0; m_wen = 0; m_addr = 0; m_data = '0;
            m_done = 0; m_short = 0; m_long = 0; m_cnt = '0;
        end else begin
            acc = valid_in && exp_rdy;
            wr = 0; waddr = 0; lg = 0; sh = 0; dn = 0;
            if (acc) begin
                lg = m_in_frame && (m_beats == N);
                if (sop_in) begin
                    wr = 1; waddr = 0;
                    sh = m_in_frame && (m_beats < N);
                    if (eop_in) begin
                        m_in_frame = 0;
                        if (N == 1) dn = 1; else sh = 1;
                    end else begin
                        m_in_frame = 1; m_beats = 1;
                    end
                end else if (m_in_frame) begin
                    if (m_beats < N) begin
                        wr = 1; waddr = m_beats;
                    end
                    if (m_beats <= N) m_beats++;
                    if (eop_in) begin
                        m_in_frame = 0;
                        if (wr) begin
                            if (m_beats == N) dn = 1; else sh = 1;
                        end
                    end
                end
            end
            if (wr) begin
                m_wen = 1; m_addr = waddr; m_data = data_in;
            end else if (mem_ready) begin
                m_wen = 0;
            end
            m_long  = lg;
            m_short = sh && !lg;
            m_done  = dn && !lg && !sh;
            if (m_done) m_cnt = m_cnt + 16'd1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input logic [11:0] d, input bit s, input bit e);
        int  n;
        bit  rdy;
        data_in = d; sop_in = s; eop_in = e; valid_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = ready_out;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("beat_timeout", 0, 1);
        #1;
        valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
    endtask

    task automatic frame(input int nb, input int eop_at, input int base);
        for (int i = 0; i < nb; i++)
            beat(12'(base + i + 1), i == 0, (i + 1) == eop_at);
    endtask

    task automatic clr();
        wlog.delete(); dlog.delete();
        n_done = 0; n_short = 0; n_long = 0;
    endtask

    task automatic chk_addrs(input string name, input int at, input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            if (at + a - lo < wlog.size())
                chk(name, wlog[at + a - lo], a);
            else
                chk({name, "_missing"}, -1, a);
        end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; sop_in = 1'b0; eop_in = 1'b0;
        data_in = '0; mem_ready = 1'b1;
        clr();
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("reset_count", int'(frame_count), 0);
        chk("reset_wr_en", int'(wr_en), 0);

        // Good 4x2 frame, data 0x001..0x008.
        clr();
        frame(8, 8, 0);
        idle(3);
        chk("s1_writes", wlog.size(), 8);
        chk_addrs("s1_addr", 0, 0, 7);
        for (int i = 0; i < 8 && i < dlog.size(); i++) chk("s1_data", dlog[i], i + 1);
        chk("s1_done", n_done, 1);
        chk("s1_count", int'(frame_count), 1);

        // Same frame with a 3-cycle write stall after the third write.
        clr();
        for (int i = 0; i < 3; i++) beat(12'(i + 1), i == 0, 1'b0);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s2_hold_addr", int'(wr_addr), 2);
            chk("s2_stall_ready", int'(ready_out), 0);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        for (int i = 3; i < 8; i++) beat(12'(i + 1), 1'b0, i == 7);
        idle(3);
        chk("s2_writes", wlog.size(), 8);
        chk_addrs("s2_addr", 0, 0, 7);
        chk("s2_done", n_done, 1);
        chk("s2_count", int'(frame_count), 2);

        // Stray beats before sop are dropped.
        clr();
        beat(12'hABC, 1'b0, 1'b0);
        beat(12'h123, 1'b0, 1'b0);
        idle(2);
        chk("s3_stray", wlog.size(), 0);
        frame(8, 8, 16);
        idle(3);
        chk_addrs("s3_addr", 0, 0, 7);
        chk("s3_count", int'(frame_count), 3);

        // Short frame: eop on beat 5.
        clr();
        frame(5, 5, 32);
        idle(3);
        chk("s4_writes", wlog.size(), 5);
        chk_addrs("s4_addr", 0, 0, 4);
        chk("s4_short", n_short, 1);
        chk("s4_count", int'(frame_count), 3);

        // Long frame: 10 beats, eop on the 10th, then a good frame.
        clr();
        frame(10, 10, 48);
        idle(3);
        chk("s5_writes", wlog.size(), 8);
        chk("s5_long", n_long, 1);
        chk("s5_nodone", n_done, 0);
        frame(8, 8, 64);
        idle(3);
        chk("s5_done", n_done, 1);
        chk("s5_count", int'(frame_count), 4);

        // Restart mid-frame after three beats, then a full frame.
        clr();
        frame(3, 0, 80);
        frame(8, 8, 96);
        idle(3);
        chk("s6_writes", wlog.size(), 11);
        chk_addrs("s6_head", 0, 0, 2);
        chk_addrs("s6_tail", 3, 0, 7);
        chk("s6_short", n_short, 1);
        chk("s6_done", n_done, 1);
        chk("s6_count", int'(frame_count), 5);

        // Reset in the middle of a frame.
        clr();
        frame(3, 0, 112);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        chk("s7_nopulse", n_short + n_long + n_done, 0);
        chk("s7_count", int'(frame_count), 0);

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            valid_in  = ($urandom_range(0, 3) != 0);
            sop_in    = ($urandom_range(0, 9) == 0);
            eop_in    = ($urandom_range(0, 7) == 0);
            data_in   = 12'($urandom);
            mem_ready = ($urandom_range(0, 4) != 0);
            reset     = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #1;
        valid_in = 1'b0; reset = 1'b0; mem_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
